data_mem_responder: RTL and testbench

// - Memory-side responder for the core's memory-stage port (MEM_V/MEM_Cst_R_W/MEM_Cst_Size/address/store data -> load data).
// - Word-organised data RAM; byte/half/word stores via lane enables; loads sign/zero-extended; same-cycle (combinational) load data.
// - Post-reset clear sequencer, sticky fault capture (misaligned/out-of-range/bad size), access counters.

---
 rtl/data_mem_responder.sv | 192 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Memory-stage data RAM responder: byte/half/word stores, sign/zero-extended loads, clear sequencer, fault capture, counters.
// Latency: load data combinational in the access cycle; stores, counters and ERR update on the next rising edge.
// Backpressure: none; accesses are silently ignored while INIT_BUSY. DMEM_TOHOST_EN adds the MMIO tohost mailbox.
module data_mem_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_0FF0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_V,
    input  logic        MEM_Cst_R_W,
    input  logic [2:0]  MEM_Cst_Size,
    input  logic [31:0] MEM_Address,
    input  logic [31:0] MEM_RES,
    output logic [31:0] MEM_Data_Out,
    output logic        INIT_BUSY,
    output logic        ERR,
    output logic [31:0] ERR_ADDR,
    output logic [31:0] RD_CNT,
    output logic [31:0] WR_CNT,
    output logic        TOHOST_V,
    output logic [31:0] TOHOST_DATA
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [32:0]           SPAN     = 33'(DEPTH) << 2;
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = DEPTH_LOG2'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

`ifdef DMEM_TOHOST_EN
    localparam bit MBOX_EN = 1'b1;
`else
    localparam bit MBOX_EN = 1'b0;
`endif

    logic [31:0]           mem [DEPTH];
    logic [0:0]            state;
    logic [DEPTH_LOG2-1:0] clr_idx;

    logic                  in_run;
    logic [31:0]           off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] widx;
    logic [1:0]            sz;
    logic                  mbox_hit;
    logic                  misalign;
    logic                  fault;
    logic                  access;
    logic                  fault_hit;
    logic                  do_load;
    logic                  do_store;
    logic                  ram_store;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [31:0]           rword;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic                  sext;
    logic [31:0]           ld_ext;

    assign in_run    = (state == ST_RUN);
    assign INIT_BUSY = (state == ST_CLEAR);

    // Address decode: offset from the window base, word index taken from the offset.
    assign off      = MEM_Address - BASE_ADDR;
    assign in_range = (MEM_Address >= BASE_ADDR) && ({1'b0, off} < SPAN);
    assign widx     = off[DEPTH_LOG2+1:2];
    assign sz       = MEM_Cst_Size[1:0];
    assign mbox_hit = MBOX_EN && (MEM_Address == TOHOST_ADDR);

    assign misalign = ((sz == SZ_HALF) && MEM_Address[0]) ||
                      ((sz == SZ_WORD) && (MEM_Address[1:0] != 2'b00));

    // The mailbox only accepts whole-word accesses; anything else there is a fault.
    assign fault = (sz == SZ_BAD) || misalign ||
                   (!in_range && !mbox_hit) ||
                   (mbox_hit && (sz != SZ_WORD));

    assign access    = in_run && MEM_V;
    assign fault_hit = access && fault;
    assign do_load   = access && !fault && !MEM_Cst_R_W;
    assign do_store  = access && !fault && MEM_Cst_R_W && !RESET;
    assign ram_store = do_store && !mbox_hit;

    // Store lane enables and replicated write data so each lane sees its bytes.
    always_comb begin
        be    = 4'b0000;
        wdata = MEM_RES;
        case (sz)
            SZ_BYTE: begin
                be    = 4'b0001 << MEM_Address[1:0];
                wdata = {4{MEM_RES[7:0]}};
            end
            SZ_HALF: begin
                be    = MEM_Address[1] ? 4'b1100 : 4'b0011;
                wdata = {2{MEM_RES[15:0]}};
            end
            SZ_WORD: begin
                be    = 4'b1111;
                wdata = MEM_RES;
            end
            default: begin
                be    = 4'b0000;
                wdata = MEM_RES;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (ram_store) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Load path: lane extraction and extension, all combinational.
    assign rword = mbox_hit ? TOHOST_DATA : mem[widx];
    assign rbyte = rword[8*MEM_Address[1:0] +: 8];
    assign rhalf = MEM_Address[1] ? rword[31:16] : rword[15:0];
    assign sext  = !MEM_Cst_Size[2];

    always_comb begin
        ld_ext = rword;
        case (sz)
            SZ_BYTE: ld_ext = {{24{sext & rbyte[7]}}, rbyte};
            SZ_HALF: ld_ext = {{16{sext & rhalf[15]}}, rhalf};
            default: ld_ext = rword;
        endcase
    end

    assign MEM_Data_Out = do_load ? ld_ext : 32'h0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_CLEAR;
            clr_idx  <= '0;
            ERR      <= 1'b0;
            ERR_ADDR <= 32'h0;
            RD_CNT   <= 32'h0;
            WR_CNT   <= 32'h0;
        end else begin
            if (state == ST_CLEAR) begin
                clr_idx <= clr_idx + DEPTH_LOG2'(1);
                if (clr_idx == LAST_IDX) begin
                    state <= ST_RUN;
                end
            end
            if (do_load) begin
                RD_CNT <= RD_CNT + 32'd1;
            end
            if (do_store) begin
                WR_CNT <= WR_CNT + 32'd1;
            end
            // First fault wins: the address is captured only while ERR is still clear.
            if (fault_hit) begin
                ERR <= 1'b1;
                if (!ERR) begin
                    ERR_ADDR <= MEM_Address;
                end
            end
        end
    end

`ifdef DMEM_TOHOST_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            TOHOST_V    <= 1'b0;
            TOHOST_DATA <= 32'h0;
        end else if (do_store && mbox_hit) begin
            TOHOST_V    <= 1'b1;
            TOHOST_DATA <= MEM_RES;
        end
    end
`else
    assign TOHOST_V    = 1'b0;
    assign TOHOST_DATA = 32'h0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a 16-word RAM at 0x1000..0x103F.
module tb_data_mem_responder;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] BAD = 3'b011;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        MEM_V = 1'b0;
    logic        MEM_Cst_R_W = 1'b0;
    logic [2:0]  MEM_Cst_Size = 3'b000;
    logic [31:0] MEM_Address = 32'h0;
    logic [31:0] MEM_RES = 32'h0;
    logic [31:0] MEM_Data_Out;
    logic        INIT_BUSY;
    logic        ERR;
    logic [31:0] ERR_ADDR;
    logic [31:0] RD_CNT;
    logic [31:0] WR_CNT;
    logic        TOHOST_V;
    logic [31:0] TOHOST_DATA;

    int          errors = 0;
    int          checks = 0;
    int          n;
    logic [31:0] rd;

    data_mem_responder #(
        .DEPTH_LOG2 (4),
        .BASE_ADDR  (32'h0000_1000),
        .TOHOST_ADDR(32'h0000_0FF0)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .MEM_V       (MEM_V),
        .MEM_Cst_R_W (MEM_Cst_R_W),
        .MEM_Cst_Size(MEM_Cst_Size),
        .MEM_Address (MEM_Address),
        .MEM_RES     (MEM_RES),
        .MEM_Data_Out(MEM_Data_Out),
        .INIT_BUSY   (INIT_BUSY),
        .ERR         (ERR),
        .ERR_ADDR    (ERR_ADDR),
        .RD_CNT      (RD_CNT),
        .WR_CNT      (WR_CNT),
        .TOHOST_V    (TOHOST_V),
        .TOHOST_DATA (TOHOST_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One access cycle; load data is sampled mid-cycle, state after the edge.
    task automatic access(input logic rw, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] dout);
        MEM_V        = 1'b1;
        MEM_Cst_R_W  = rw;
        MEM_Cst_Size = size;
        MEM_Address  = addr;
        MEM_RES      = wd;
        #2;
        dout = MEM_Data_Out;
        tick();
        MEM_V       = 1'b0;
        MEM_Cst_R_W = 1'b0;
    endtask

    task automatic wait_clear(output int cnt);
        cnt = 0;
        while (INIT_BUSY === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        chk("rst_init_busy", 32'(INIT_BUSY), 32'd1);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_err_addr", ERR_ADDR, 32'h0);
        chk("rst_rd_cnt", RD_CNT, 32'h0);
        chk("rst_wr_cnt", WR_CNT, 32'h0);
        chk("rst_tohost_v", 32'(TOHOST_V), 32'd0);
        chk("rst_tohost_data", TOHOST_DATA, 32'h0);

        for (int i = 0; i < 8; i++) tick();
        chk("busy_at_cycle8", 32'(INIT_BUSY), 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;

        // Restarted clear; poke the port mid-sequence, which must be ignored.
        n = 0;
        while (INIT_BUSY === 1'b1 && n < 100) begin
            if (n == 10) begin
                MEM_V = 1'b1; MEM_Cst_R_W = 1'b1; MEM_Cst_Size = SW;
                MEM_Address = 32'h1000; MEM_RES = 32'hFFFF_FFFF;
            end else if (n == 11) begin
                MEM_V = 1'b1; MEM_Cst_R_W = 1'b0; MEM_Cst_Size = BAD;
                MEM_Address = 32'h1000;
            end else begin
                MEM_V = 1'b0; MEM_Cst_R_W = 1'b0;
            end
            if (n == 11) begin
                #2;
                chk("clear_load_data", MEM_Data_Out, 32'h0);
            end
            tick();
            n++;
        end
        MEM_V = 1'b0;
        MEM_Cst_R_W = 1'b0;
        chk("clear_cycles_after_restart", 32'(n), 32'd16);
        chk("clear_err", 32'(ERR), 32'd0);
        chk("clear_rd_cnt", RD_CNT, 32'h0);
        chk("clear_wr_cnt", WR_CNT, 32'h0);

        access(1'b0, LW, 32'h1000, 32'h0, rd); chk("lw_first_word", rd, 32'h0);
        access(1'b0, LW, 32'h103C, 32'h0, rd); chk("lw_last_word", rd, 32'h0);

        access(1'b1, SW, 32'h1000, 32'hDEAD_BEEF, rd); chk("store_data_out", rd, 32'h0);
        access(1'b0, LB,  32'h1003, 32'h0, rd); chk("lb_1003", rd, 32'hFFFF_FFDE);
        access(1'b0, LBU, 32'h1003, 32'h0, rd); chk("lbu_1003", rd, 32'h0000_00DE);
        access(1'b0, LH,  32'h1000, 32'h0, rd); chk("lh_1000", rd, 32'hFFFF_BEEF);
        chk("rd_cnt_5", RD_CNT, 32'd5);
        chk("wr_cnt_1", WR_CNT, 32'd1);
        access(1'b0, LHU, 32'h1002, 32'h0, rd); chk("lhu_1002", rd, 32'h0000_DEAD);

        access(1'b1, SB, 32'h1001, 32'hAAAA_AA12, rd);
        access(1'b0, LW, 32'h1000, 32'h0, rd); chk("lw_after_sb", rd, 32'hDEAD_12EF);
        access(1'b1, SH, 32'h1002, 32'hFFFF_5678, rd);
        access(1'b0, LW, 32'h1000, 32'h0, rd); chk("lw_after_sh", rd, 32'h5678_12EF);

        access(1'b1, SW, 32'h103C, 32'h1122_3344, rd);
        access(1'b0, LW, 32'h103C, 32'h0, rd); chk("lw_last_after_sw", rd, 32'h1122_3344);
        access(1'b0, LB, 32'h103C, 32'h0, rd); chk("lb_103c", rd, 32'h0000_0044);
        access(1'b0, LH, 32'h103E, 32'h0, rd); chk("lh_103e", rd, 32'h0000_1122);
        access(1'b0, LB, 32'h1000, 32'h0, rd); chk("lb_1000", rd, 32'hFFFF_FFEF);
        chk("rd_cnt_12", RD_CNT, 32'd12);
        chk("wr_cnt_4", WR_CNT, 32'd4);
        chk("no_err_yet", 32'(ERR), 32'd0);

        access(1'b0, LW, 32'h1002, 32'h0, rd); chk("lw_misaligned_data", rd, 32'h0);
        chk("err_set", 32'(ERR), 32'd1);
        chk("err_addr_first", ERR_ADDR, 32'h1002);
        chk("rd_cnt_after_fault", RD_CNT, 32'd12);
        access(1'b1, SW, 32'h0000_0000, 32'h5555_5555, rd);
        chk("err_addr_kept", ERR_ADDR, 32'h1002);
        chk("wr_cnt_after_oor", WR_CNT, 32'd4);
        access(1'b1, SW, 32'h1040, 32'hCAFE_BABE, rd);
        chk("wr_cnt_after_1040", WR_CNT, 32'd4);
        access(1'b0, LW, 32'h1000, 32'h0, rd); chk("no_alias_1040", rd, 32'h5678_12EF);
        access(1'b0, LW, 32'h0FFC, 32'h0, rd); chk("lw_below_base", rd, 32'h0);
        access(1'b0, BAD, 32'h1000, 32'h0, rd); chk("bad_size_load", rd, 32'h0);
        access(1'b0, LH, 32'h1001, 32'h0, rd); chk("lh_misaligned", rd, 32'h0);
        access(1'b1, SH, 32'h1003, 32'h0000_FFFF, rd);
        access(1'b0, LW, 32'h1000, 32'h0, rd); chk("sh_misaligned_dropped", rd, 32'h5678_12EF);
        chk("rd_cnt_14", RD_CNT, 32'd14);
        chk("wr_cnt_still_4", WR_CNT, 32'd4);
        chk("err_addr_final", ERR_ADDR, 32'h1002);

        // Fresh reset: RAM must be wiped, then exercise the mailbox address.
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rst2_err", 32'(ERR), 32'd0);
        chk("rst2_rd_cnt", RD_CNT, 32'h0);
        wait_clear(n);
        chk("rst2_clear_cycles", 32'(n), 32'd16);
        access(1'b0, LW, 32'h1000, 32'h0, rd); chk("ram_wiped", rd, 32'h0);
        access(1'b1, SW, 32'h0FF0, 32'h0000_0001, rd);
`ifdef DMEM_TOHOST_EN
        chk("tohost_v", 32'(TOHOST_V), 32'd1);
        chk("tohost_data", TOHOST_DATA, 32'h1);
        chk("tohost_no_err", 32'(ERR), 32'd0);
        chk("tohost_wr_cnt", WR_CNT, 32'd1);
        access(1'b0, LW, 32'h0FF0, 32'h0, rd); chk("tohost_readback", rd, 32'h1);
        chk("tohost_rd_cnt", RD_CNT, 32'd2);
        access(1'b0, LB, 32'h0FF0, 32'h0, rd); chk("tohost_byte_data", rd, 32'h0);
        chk("tohost_byte_err", 32'(ERR), 32'd1);
        chk("tohost_byte_err_addr", ERR_ADDR, 32'h0FF0);
`else
        chk("tohost_addr_err", 32'(ERR), 32'd1);
        chk("tohost_addr_err_addr", ERR_ADDR, 32'h0FF0);
        chk("tohost_addr_wr_cnt", WR_CNT, 32'd0);
        chk("tohost_v_tied", 32'(TOHOST_V), 32'd0);
        chk("tohost_data_tied", TOHOST_DATA, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
